// File: rtl/rotor_reverse.sv
// rotor_reverse: return-path rotor stage; loads forward wiring, builds and validates its inverse, maps left_in to right_out.
`timescale 1ns/1ps
module rotor_reverse #(
  parameter logic [4:0] TURNOVER = 5'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_clear,
  input  logic       cfg_valid,
  input  logic [4:0] cfg_data,
  output logic       cfg_ready,
  output logic       wiring_ready,
  output logic       wiring_err,
  input  logic       en,
  input  logic       load,
  input  logic       inc,
  input  logic [4:0] pos_in,
  input  logic [4:0] left_in,
  output logic [4:0] right_out,
  output logic       is_at_turnover
);
  typedef enum logic [1:0] {EMPTY, FILL, READY, ERR} state_t;
  state_t      r_state, w_next;
  logic [4:0]  r_cnt, r_idx;
  logic [25:0] r_seen;
  logic [4:0]  r_inv [26];
  logic [31:0] w_seen32;
  logic        w_acc, w_bad;
  logic [5:0]  w_sum, w_iv, w_cnt6;
  logic [4:0]  w_contact;
  assign w_seen32  = {6'b0, r_seen};
  assign w_acc     = cfg_valid & cfg_ready & ~cfg_clear;
  assign w_bad     = (cfg_data > 5'd25) | w_seen32[cfg_data];
  assign cfg_ready = (r_state == EMPTY) | (r_state == FILL);
  assign wiring_ready = r_state == READY;
  assign wiring_err   = r_state == ERR;
  assign is_at_turnover = r_cnt == TURNOVER;
  always_comb begin
    w_next = r_state;
    if (cfg_clear) w_next = EMPTY;
    else if (w_acc) w_next = w_bad ? ERR : (r_idx == 5'd25 ? READY : FILL);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= EMPTY;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx  <= '0;
      r_seen <= '0;
      for (int i = 0; i < 26; i++) r_inv[i] <= 5'd31;
    end else if (cfg_clear) begin
      r_idx  <= '0;
      r_seen <= '0;
      for (int i = 0; i < 26; i++) r_inv[i] <= 5'd31;
    end else if (w_acc && !w_bad) begin
      r_inv[cfg_data]  <= r_idx;
      r_seen[cfg_data] <= 1'b1;
      r_idx            <= r_idx + 5'd1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (en) r_cnt <= load ? (pos_in > 5'd25 ? 5'd0 : pos_in)
                        : inc ? (r_cnt == 5'd25 ? 5'd0 : r_cnt + 5'd1) : r_cnt;
  // Modular arithmetic done in 6 bits with a single conditional correction by 26.
  assign w_cnt6    = {1'b0, r_cnt};
  assign w_sum     = {1'b0, left_in} + w_cnt6;
  assign w_contact = 5'(w_sum >= 6'd26 ? w_sum - 6'd26 : w_sum);
  assign w_iv      = {1'b0, r_inv[w_contact]};
  assign right_out = (r_state == READY && left_in <= 5'd25)
                   ? 5'(w_iv >= w_cnt6 ? w_iv - w_cnt6 : w_iv + 6'd26 - w_cnt6) : 5'd31;
endmodule

// File: tb/tb_rotor_reverse.sv
// tb_rotor_reverse: randomized and directed checks of rotor_reverse against a permutation-level reference model.
`timescale 1ns/1ps
module tb_rotor_reverse;
  logic clk = 0, rst_n = 0, cfg_clear = 0, cfg_valid = 0, en = 0, load = 0, inc = 0;
  logic [4:0] cfg_data = 0, pos_in = 0, left_in = 0, right_out;
  logic cfg_ready, wiring_ready, wiring_err, is_at_turnover;
  int checks = 0, failures = 0;
  int m_state, m_cnt;
  int m_beats[$];
  int rotor1[26] = '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9};
  int perm[26];
  rotor_reverse #(.TURNOVER(5'd16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_clear(cfg_clear), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .wiring_ready(wiring_ready), .wiring_err(wiring_err), .en(en), .load(load),
    .inc(inc), .pos_in(pos_in), .left_in(left_in), .right_out(right_out), .is_at_turnover(is_at_turnover));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int find(input int v);
    foreach (m_beats[i]) if (m_beats[i] == v) return i;
    return -1;
  endfunction
  // Expected right contact: the forward-wiring input that reaches the rotated left contact.
  function automatic int exp_right(input int l);
    int c;
    if (m_state != 2 || l > 25) return 31;
    c = find((l + m_cnt) % 26);
    return ((c - m_cnt) % 26 + 26) % 26;
  endfunction
  task automatic check_all();
    chk("cfg_ready", cfg_ready, m_state < 2);
    chk("wiring_ready", wiring_ready, m_state == 2);
    chk("wiring_err", wiring_err, m_state == 3);
    chk("turnover", is_at_turnover, m_cnt == 16);
    chk("right_out", right_out, exp_right(left_in));
  endtask
  task automatic model_edge();
    if (cfg_clear) begin m_state = 0; m_beats.delete(); end
    else if (cfg_valid && m_state < 2) begin
      if (cfg_data > 25 || find(cfg_data) >= 0) m_state = 3;
      else begin m_beats.push_back(cfg_data); m_state = m_beats.size() == 26 ? 2 : 1; end
    end
    if (en) m_cnt = load ? (pos_in > 25 ? 0 : pos_in) : inc ? (m_cnt == 25 ? 0 : m_cnt + 1) : m_cnt;
  endtask
  task automatic cyc();
    model_edge();
    @(posedge clk); #1;
    check_all();
  endtask
  task automatic idle();
    cfg_clear = 0; cfg_valid = 0; en = 0; load = 0; inc = 0;
  endtask
  task automatic beat(input int d);
    cfg_valid = 1; cfg_data = 5'(d); cyc(); cfg_valid = 0;
  endtask
  task automatic look(input int l);
    left_in = 5'(l); #1; check_all();
  endtask
  task automatic clear();
    cfg_clear = 1; cyc(); cfg_clear = 0;
  endtask
  task automatic async_reset();
    rst_n = 0; #1;
    m_state = 0; m_cnt = 0; m_beats.delete();
    check_all();
    chk("rst_right_out", right_out, 31);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1; #1;
  endtask
  initial begin
    idle();
    @(posedge clk); #1;
    async_reset();
    for (int i = 0; i < 26; i++) begin
      beat(i);
      if (i == 24) chk("id_not_ready", wiring_ready, 0);
    end
    chk("id_ready", wiring_ready, 1);
    chk("id_cfg_ready", cfg_ready, 0);
    look(7);  chk("id_l7", right_out, 7);
    look(30); chk("id_l30", right_out, 31);
    clear();
    foreach (rotor1[i]) beat(rotor1[i]);
    look(4);  chk("r1_l4", right_out, 0);
    look(9);  chk("r1_l9", right_out, 25);
    look(16); chk("r1_l16", right_out, 7);
    en = 1; load = 1; pos_in = 1; cyc(); idle();
    look(3);  chk("r1_rot_l3", right_out, 25);
    en = 1; inc = 1;
    for (int i = 0; i < 24; i++) cyc();
    cyc(); idle();
    look(4);  chk("r1_wrap_l4", right_out, 0);
    en = 1; load = 1; inc = 1; pos_in = 5; cyc(); idle();
    look(0);  chk("ldinc_l0", right_out, (find(5) - 5 + 26) % 26);
    en = 1; load = 1; pos_in = 28; cyc(); idle();
    look(4);  chk("ld28_l4", right_out, 0);
    en = 0; inc = 1; cyc(); idle();
    look(4);  chk("noen_l4", right_out, 0);
    en = 1; load = 1; pos_in = 16; cyc(); idle();
    chk("turn_at16", is_at_turnover, 1);
    en = 1; inc = 1; cyc(); idle();
    chk("turn_at17", is_at_turnover, 0);
    clear();
    beat(4); beat(10); beat(4);
    chk("dup_err", wiring_err, 1);
    chk("dup_cfg_ready", cfg_ready, 0);
    chk("dup_right_out", right_out, 31);
    beat(7);
    chk("err_sticky", wiring_err, 1);
    clear();
    chk("clr_cfg_ready", cfg_ready, 1);
    chk("clr_err", wiring_err, 0);
    beat(3); beat(27);
    chk("big_err", wiring_err, 1);
    clear();
    for (int i = 0; i < 10; i++) beat(rotor1[i]);
    async_reset();
    foreach (rotor1[i]) beat(rotor1[i]);
    chk("restream_ready", wiring_ready, 1);
    clear();
    for (int i = 0; i < 25; i++) beat(i);
    cfg_clear = 1; cfg_valid = 1; cfg_data = 25; cyc(); idle();
    chk("clr_beat_ready", wiring_ready, 0);
    chk("clr_beat_cfg_ready", cfg_ready, 1);
    for (int it = 0; it < 8; it++) begin
      clear();
      for (int i = 0; i < 26; i++) perm[i] = i;
      for (int i = 25; i > 0; i--) begin
        int j, t;
        j = $urandom_range(i, 0); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      if (it % 3 == 2) perm[$urandom_range(25, 1)] = ($urandom_range(1, 0) != 0) ? perm[0] : 26 + $urandom_range(5, 0);
      for (int i = 0; i < 26; ) begin
        en = $urandom_range(1, 0) != 0; load = $urandom_range(7, 0) == 0; inc = $urandom_range(1, 0) != 0;
        pos_in = 5'($urandom); left_in = 5'($urandom);
        if ($urandom_range(3, 0) != 0) begin beat(perm[i]); i++; end
        else cyc();
      end
      idle();
      for (int k = 0; k < 60; k++) begin
        en = $urandom_range(1, 0) != 0; load = $urandom_range(7, 0) == 0; inc = $urandom_range(1, 0) != 0;
        pos_in = 5'($urandom);
        cfg_valid = $urandom_range(7, 0) == 0; cfg_data = 5'($urandom);
        cyc(); idle();
        look($urandom_range(31, 0));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rotor_reverse.md
# rotor_reverse

Programmable left-to-right (return-path) rotor stage for the Enigma datapath. It is loaded once with a rotor's forward wiring as a 26-beat stream, builds the inverse permutation internally, and checks that the wiring is a valid permutation. It then maps the signal returning from the reflector (`left_in`) to the absolute contact on its right side (`right_out`). It keeps its own rotation counter with the same load/inc/turnover semantics as the forward rotor stage, so the two stay in lock-step when driven by the same controls.

## Interface
- `TURNOVER`, default 5'd16: counter value at which `is_at_turnover` asserts (16 = Q).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_clear` in 1: synchronous pulse; discards the wiring and restarts configuration.
- `cfg_valid` in 1: a wiring beat is presented on `cfg_data`.
- `cfg_data` in 5: forward wiring output for contact i, where i is the beat index 0..25.
- `cfg_ready` out 1: block accepts a beat when `cfg_valid & cfg_ready`.
- `wiring_ready` out 1: 26 valid beats have been accepted and the inverse table is usable.
- `wiring_err` out 1: the wiring stream was invalid (duplicate value or value > 25).
- `en` in 1: counter update enable.
- `load` in 1: with `en`, loads `pos_in` into the counter.
- `inc` in 1: with `en` and no `load`, steps the counter.
- `pos_in` in 5: rotor start position.
- `left_in` in 5: absolute position entering from the left.
- `right_out` out 5: absolute position leaving to the right; 31 when not `wiring_ready`.
- `is_at_turnover` out 1: `cnt == TURNOVER`.

## Operation
- **State.** `cfg_state` takes one of four values: EMPTY, FILL, READY, ERR.
- **Registers:**
  - `cnt[4:0]`: rotation, 0..25.
  - `idx[4:0]`: number of accepted beats.
  - `seen[25:0]`: marks forward-output values already received.
  - `inv[0..25][4:0]`: the inverse table.
- **EMPTY → FILL:** on the first accepted beat.
- **Beat handling (EMPTY/FILL).** `cfg_ready = 1`. For each accepted beat `d`:
  - If `d > 25` or `seen[d]` is set, go to ERR. No table write occurs.
  - Otherwise write `inv[d] <= idx`, set `seen[d]`, and do `idx <= idx + 1`.
  - If this beat has `idx == 25`, go to READY.
- **READY.** `cfg_ready = 0`. Further beats are not accepted and are ignored.
- **ERR.** `cfg_ready = 0` and `wiring_err = 1`. The block stays here until `cfg_clear` or reset.
- **`cfg_clear`, any state.** Next state is EMPTY. `idx`, `seen` and all `inv` entries (to 31) are cleared.
  - `cfg_clear` has priority over a same-cycle beat; that beat is dropped.
- **Flags.** `wiring_ready = (cfg_state == READY)` and `wiring_err = (cfg_state == ERR)`.
- **Return path.** Combinational and valid only in READY:
  - `contact = (left_in + cnt) mod 26`
  - `right_out = (inv[contact] - cnt) mod 26`
  - All arithmetic is in the range 0..25. Use 6-bit intermediates and a conditional subtract or add of 26. Raw 5-bit wrap is not allowed.
  - `left_in > 25` gives `right_out = 31`.
  - In any state other than READY, `right_out = 31`.
- **Counter.** Independent of `cfg_state`. On `en`:
  - `load` gives `cnt <= (pos_in > 25) ? 0 : pos_in`.
  - Otherwise `inc` gives `cnt <= (cnt == 25) ? 0 : cnt + 1`.
  - `load` has priority over `inc`.
  - Without `en`, `cnt` holds.
- **Turnover.** `is_at_turnover` is combinational from `cnt`.

## Timing
- **Reset values (async assert):**
  - `cnt = 0`, `idx = 0`, `seen = 0`, all `inv = 31`, `cfg_state = EMPTY`.
  - Outputs: `cfg_ready = 1`, `wiring_ready = 0`, `wiring_err = 0`, `right_out = 31`.
  - `is_at_turnover = 0` for `TURNOVER != 0`.
- **Reset release.** Deassertion is synchronous to `clk` at the integration level. The first beat can be accepted on the first rising edge after release.
- **Configuration rate.** One beat per cycle, with no bubbles required.
  - `wiring_ready` rises the cycle after the 26th accepted beat, so there are 26 cycles minimum from the first beat.
  - `cfg_ready` falls in the same cycle that `wiring_ready` rises.
- **Error timing.** `wiring_err` rises the cycle after the offending beat.
- **Counter timing.**
  - `cnt` changes one edge after `en` is asserted.
  - `right_out` and `is_at_turnover` reflect the new `cnt` in that same cycle, after the edge.
  - `right_out` has zero-cycle latency from `left_in`.
- **Reset mid-configuration.** All progress is lost and the block returns to EMPTY. A partial table is never exposed.

## Test plan
- **Identity wiring.** Reset, then stream 0..25 with `cnt = 0`. Expect `wiring_ready = 1` exactly one cycle after the 26th beat and `cfg_ready = 0`. Then `left_in = 7` gives `right_out = 7`, and `left_in = 30` gives 31.
- **Rotor-I inverse lookup.** Stream rotor-I forward wiring EKMFLGDQVZNTOWYHXUSPAIBRCJ (4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9) with `cnt = 0`. Expect `left_in = 4` → 0, `left_in = 9` → 25, `left_in = 16` → 7.
- **Rotated lookup.** With rotor-I loaded, apply `en = 1`, `load = 1`, `pos_in = 1`. Expect `left_in = 3` → 25. Then apply `inc` 24 times (`cnt = 25`) and one more `inc` (`cnt = 0`); `left_in = 4` → 0.
- **Invalid wiring and recovery.** Send beats 4, 10, 4. Expect `wiring_err = 1` and `cfg_ready = 0` the next cycle, with `right_out = 31`. A fourth beat is ignored. `cfg_clear` gives EMPTY with `cfg_ready = 1`. Separately, a beat of 27 also leads to ERR.
- **Counter edge cases.**
  - `load` and `inc` in the same cycle with `pos_in = 5` gives `cnt = 5`.
  - `pos_in = 28` loads 0.
  - `is_at_turnover` is 1 only at `cnt = 16`.
  - `en = 0` with `inc = 1` leaves `cnt` unchanged.
- **Reset and clear mid-fill.**
  - After 10 beats, pulse `rst_n` low without a clock edge. Expect outputs at their reset values immediately. A full 26-beat restream reaches READY.
  - `cfg_clear` together with `cfg_valid` on beat 26 leaves EMPTY with `wiring_ready = 0`.
